// File: rtl/fp_add_unit.sv
// Multi-cycle floating-point add/subtract unit: IDLE -> ALIGN -> ADD -> NORM -> DONE.
// Truncating rounding, denormals flushed to zero, overflow saturates to infinity.
module fp_add_unit #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 sub,
  input  logic [EXP_W+MAN_W:0] number1,
  input  logic [EXP_W+MAN_W:0] number2,
  output logic                 in_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 result_ready,
  input  logic                 result_ack,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned SW  = MAN_W + 2;
  localparam int unsigned EW  = EXP_W + 2;
  localparam int unsigned LZW = $clog2(MAN_W + 1);

  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [W-1:0]     CANON_NAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StDone} state_e;

  state_e r_state, w_state_next;

  // Operand registers
  logic [W-1:0] r_a, r_b;
  logic         r_sub;

  // Aligned operands
  logic         r_special;
  logic [W-1:0] r_special_val;
  logic         r_sign;
  logic         r_eff_sub;
  logic [EXP_W-1:0] r_exp;
  logic [SW-1:0] r_big;
  logic [SW-1:0] r_small;

  // Raw sum
  logic [SW-1:0] r_sum;

  // Outputs
  logic [W-1:0] r_result;
  logic         r_result_ready;
  logic         r_overflow;
  logic         r_underflow;

  // ---------------------------------------------------------------------------
  // Operand decode (effective sign of b includes the subtract request)
  // ---------------------------------------------------------------------------
  logic             w_a_sign, w_b_sign;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_man, w_b_man;
  logic             w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  assign w_a_sign = r_a[W-1];
  assign w_a_exp  = r_a[W-2:MAN_W];
  assign w_a_man  = r_a[MAN_W-1:0];
  assign w_b_sign = r_b[W-1] ^ r_sub;
  assign w_b_exp  = r_b[W-2:MAN_W];
  assign w_b_man  = r_b[MAN_W-1:0];

  assign w_a_zero = (w_a_exp == '0);
  assign w_b_zero = (w_b_exp == '0);
  assign w_a_nan  = (w_a_exp == EXP_ONES) && (w_a_man != '0);
  assign w_b_nan  = (w_b_exp == EXP_ONES) && (w_b_man != '0);
  assign w_a_inf  = (w_a_exp == EXP_ONES) && (w_a_man == '0);
  assign w_b_inf  = (w_b_exp == EXP_ONES) && (w_b_man == '0);

  // NaN, infinity and zero operands bypass the arithmetic path entirely.
  logic         w_special;
  logic [W-1:0] w_special_val;

  always_comb begin
    w_special     = 1'b1;
    w_special_val = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_sign != w_b_sign))) begin
      w_special_val = CANON_NAN;
    end else if (w_a_inf) begin
      w_special_val = r_a;
    end else if (w_b_inf) begin
      w_special_val = {w_b_sign, w_b_exp, w_b_man};
    end else if (w_a_zero && w_b_zero) begin
      w_special_val = {w_a_sign & w_b_sign, {(W-1){1'b0}}};
    end else if (w_a_zero) begin
      w_special_val = {w_b_sign, w_b_exp, w_b_man};
    end else if (w_b_zero) begin
      w_special_val = r_a;
    end else begin
      w_special = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment: larger magnitude first, smaller significand shifted right
  // ---------------------------------------------------------------------------
  logic             w_a_ge;
  logic             w_big_sign;
  logic [EXP_W-1:0] w_big_exp, w_small_exp, w_exp_diff;
  logic [MAN_W-1:0] w_big_man, w_small_man;
  logic [SW-1:0]    w_small_sig, w_small_shift;

  assign w_a_ge = ({w_a_exp, w_a_man} >= {w_b_exp, w_b_man});

  always_comb begin
    if (w_a_ge) begin
      w_big_sign  = w_a_sign;
      w_big_exp   = w_a_exp;
      w_big_man   = w_a_man;
      w_small_exp = w_b_exp;
      w_small_man = w_b_man;
    end else begin
      w_big_sign  = w_b_sign;
      w_big_exp   = w_b_exp;
      w_big_man   = w_b_man;
      w_small_exp = w_a_exp;
      w_small_man = w_a_man;
    end
  end

  assign w_exp_diff    = w_big_exp - w_small_exp;
  assign w_small_sig   = {2'b01, w_small_man};
  assign w_small_shift = (32'(w_exp_diff) >= SW) ? '0 : (w_small_sig >> w_exp_diff);

  // ---------------------------------------------------------------------------
  // Significand add / subtract (big >= small, so subtraction never wraps)
  // ---------------------------------------------------------------------------
  logic [SW-1:0] w_sum;

  always_comb begin
    if (r_eff_sub) w_sum = r_big - r_small;
    else           w_sum = r_big + r_small;
  end

  // ---------------------------------------------------------------------------
  // Normalisation and packing
  // ---------------------------------------------------------------------------
  logic [LZW-1:0]   w_lead_pos, w_lz;
  logic [EW-1:0]    w_exp_ext, w_norm_exp;
  logic [MAN_W-1:0] w_norm_man;
  logic             w_norm_low, w_norm_high;

  always_comb begin
    w_lead_pos = '0;
    for (int unsigned i = 0; i <= MAN_W; i++) begin
      if (r_sum[i]) w_lead_pos = LZW'(i);
    end
  end

  assign w_lz      = LZW'(MAN_W) - w_lead_pos;
  assign w_exp_ext = EW'(r_exp);

  // The leading one shifts out of the fraction field, leaving just the stored bits.
  always_comb begin
    if (r_sum[SW-1]) begin
      w_norm_man = r_sum[MAN_W:1];
      w_norm_exp = w_exp_ext + EW'(1);
    end else begin
      w_norm_man = r_sum[MAN_W-1:0] << w_lz;
      w_norm_exp = w_exp_ext - EW'(w_lz);
    end
  end

  assign w_norm_low  = w_norm_exp[EW-1] || (w_norm_exp == '0);
  assign w_norm_high = !w_norm_exp[EW-1] && (w_norm_exp >= EW'(EXP_ONES));

  logic [W-1:0] w_pack;
  logic         w_pack_ovf, w_pack_unf;

  always_comb begin
    w_pack     = '0;
    w_pack_ovf = 1'b0;
    w_pack_unf = 1'b0;
    if (r_special) begin
      w_pack = r_special_val;
    end else if (r_sum == '0) begin
      w_pack = '0;
    end else if (w_norm_low) begin
      w_pack     = {r_sign, {(W-1){1'b0}}};
      w_pack_unf = 1'b1;
    end else if (w_norm_high) begin
      w_pack     = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
      w_pack_ovf = 1'b1;
    end else begin
      w_pack = {r_sign, w_norm_exp[EXP_W-1:0], w_norm_man};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (load) w_state_next = StAlign;
      StAlign: w_state_next = StAdd;
      StAdd:   w_state_next = StNorm;
      StNorm:  w_state_next = StDone;
      StDone:  if (result_ack) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a            <= '0;
      r_b            <= '0;
      r_sub          <= 1'b0;
      r_special      <= 1'b0;
      r_special_val  <= '0;
      r_sign         <= 1'b0;
      r_eff_sub      <= 1'b0;
      r_exp          <= '0;
      r_big          <= '0;
      r_small        <= '0;
      r_sum          <= '0;
      r_result       <= '0;
      r_result_ready <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (load) begin
            r_a   <= number1;
            r_b   <= number2;
            r_sub <= sub;
          end
        end
        StAlign: begin
          r_special     <= w_special;
          r_special_val <= w_special_val;
          r_sign        <= w_big_sign;
          r_eff_sub     <= w_a_sign ^ w_b_sign;
          r_exp         <= w_big_exp;
          r_big         <= {2'b01, w_big_man};
          r_small       <= w_small_shift;
        end
        StAdd: begin
          r_sum <= w_sum;
        end
        StNorm: begin
          r_result       <= w_pack;
          r_overflow     <= w_pack_ovf;
          r_underflow    <= w_pack_unf;
          r_result_ready <= 1'b1;
        end
        StDone: begin
          if (result_ack) begin
            r_result_ready <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == StIdle);
  assign result       = r_result;
  assign result_ready = r_result_ready;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fp_add_unit.sv
// Scoreboard bench for fp_add_unit: expected results queued at load, checked at result_ready.
module tb_fp_add_unit;

  logic        clk;
  logic        reset;
  logic        load;
  logic        sub;
  logic [31:0] number1;
  logic [31:0] number2;
  logic        in_ready;
  logic [31:0] result;
  logic        result_ready;
  logic        result_ack;
  logic        overflow;
  logic        underflow;

  fp_add_unit #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .sub          (sub),
    .number1      (number1),
    .number2      (number2),
    .in_ready     (in_ready),
    .result       (result),
    .result_ready (result_ready),
    .result_ack   (result_ack),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle load at the current negedge; leaves the bench one negedge later.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] r, input logic o, input logic u);
    exp_t e;
    e.res = r;
    e.ovf = o;
    e.unf = u;
    sb.push_back(e);
    number1 = a;
    number2 = b;
    sub     = s;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // lat0 is the number of negedges already elapsed since the load negedge.
  task automatic wait_result(input string tag, input int lat0);
    int   lat;
    exp_t e;
    lat = lat0;
    while (!result_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    if (!result_ready) begin
      check_eq({tag, "_timeout"}, 64'(result_ready), 64'(1));
      return;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(4));
    check_eq({tag, "_res"}, 64'(result), 64'(e.res));
    check_eq({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
    check_eq({tag, "_unf"}, 64'(underflow), 64'(e.unf));
    check_eq({tag, "_busy"}, 64'(in_ready), 64'(0));
  endtask

  task automatic ack_op(input string tag);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check_eq({tag, "_ack_rdy"}, 64'(result_ready), 64'(0));
    check_eq({tag, "_ack_idle"}, 64'(in_ready), 64'(1));
    check_eq({tag, "_ack_flags"}, 64'({overflow, underflow}), 64'(0));
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] r, input logic o, input logic u);
    start_op(a, b, s, r, o, u);
    wait_result(tag, 1);
    ack_op(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check_eq({tag, "_result"}, 64'(result), 64'(0));
    check_eq({tag, "_rdy"}, 64'(result_ready), 64'(0));
    check_eq({tag, "_flags"}, 64'({overflow, underflow}), 64'(0));
  endtask

  initial begin
    // Reset with a coincident load that must be discarded.
    reset      = 1'b1;
    load       = 1'b1;
    sub        = 1'b0;
    number1    = 32'h3F80_0000;
    number2    = 32'h3F80_0000;
    result_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // First cycle after reset accepts a load.
    reset = 1'b0;
    run_vec("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);

    run_vec("three_minus_three", 32'h4040_0000, 32'h4040_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    run_vec("shift_saturate", 32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    run_vec("max_overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    run_vec("nan_in", 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0);
    run_vec("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0);
    run_vec("min_underflow", 32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    run_vec("three_minus_one", 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0, 1'b0);
    run_vec("neg_cancel", 32'hBF80_0000, 32'h3F80_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    run_vec("carry_norm", 32'h3FC0_0000, 32'h3FA0_0000, 1'b0, 32'h4030_0000, 1'b0, 1'b0);
    run_vec("truncate", 32'h3F80_0001, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    run_vec("small_diff", 32'h0100_0000, 32'h0080_0000, 1'b1, 32'h0080_0000, 1'b0, 1'b0);
    run_vec("zero_plus_x", 32'h0000_0000, 32'h4040_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0);
    run_vec("zero_minus_one", 32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 1'b0, 1'b0);
    run_vec("nz_plus_nz", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    run_vec("nz_plus_pz", 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    run_vec("nz_minus_pz", 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    run_vec("neginf_plus_1", 32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 1'b0, 1'b0);
    run_vec("one_minus_inf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b0, 1'b0);

    // result_ack while in ALIGN has no effect on the run.
    start_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    wait_result("early_ack", 2);
    ack_op("early_ack");

    // Result held in DONE while loads are pulsed and ack is withheld.
    start_op(32'h3FC0_0000, 32'h3FA0_0000, 1'b0, 32'h4030_0000, 1'b0, 1'b0);
    wait_result("hold", 1);
    for (int i = 0; i < 10; i++) begin
      number1 = $urandom;
      number2 = $urandom;
      sub     = 1'(i);
      load    = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check_eq("hold_res", 64'(result), 64'h4030_0000);
      check_eq("hold_flags", 64'({overflow, underflow}), 64'(0));
      check_eq("hold_busy", 64'(in_ready), 64'(0));
      check_eq("hold_rdy", 64'(result_ready), 64'(1));
    end
    // A load in the ack cycle is ignored.
    number1    = 32'h3F80_0000;
    number2    = 32'h3F80_0000;
    load       = 1'b1;
    result_ack = 1'b1;
    @(negedge clk);
    load       = 1'b0;
    result_ack = 1'b0;
    check_eq("hold_ack_idle", 64'(in_ready), 64'(1));
    check_eq("hold_ack_rdy", 64'(result_ready), 64'(0));
    @(negedge clk);
    check_eq("hold_ack_load_ignored", 64'(in_ready), 64'(1));
    run_vec("after_hold", 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0, 1'b0);

    // Reset during ALIGN aborts the run.
    start_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    check_reset_outputs("rst_align");
    @(negedge clk);
    check_eq("rst_align_stay_idle", 64'(in_ready), 64'(1));
    run_vec("rst_align_next", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0);

    // Reset during DONE clears a held overflow result.
    start_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    wait_result("rst_done_pre", 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst_done");
    run_vec("rst_done_next", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
